decade_timer_ctrl: RTL
======================

# decade_timer_ctrl

Sequencing controller for one decade counter. It loads a programmed preset, enables counting in the chosen direction until the counter's terminal count, and repeats for a programmed number of intervals. It reports progress with tick, done and aborted pulses. It sits between the host control logic and a single decade counter instance: it owns all of the counter's control inputs and observes its count and TC outputs.

## Interface
- No parameters. Digit width is fixed at 4 bits and the modulus is fixed at 10.
- clk  in  1  rising-edge clock, shared with the decade counter
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate a run; effective in any non-IDLE state
- pause  in  1  freeze counting while high, in RUN only
- mode_up  in  1  direction, captured at start: 1 = up, 0 = down
- preset  in  4  start digit, captured at start
- reps  in  4  number of intervals, captured at start
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse when a run completes
- aborted  out  1  one-cycle pulse when a run is aborted
- tick  out  1  one-cycle pulse per completed interval
- reps_left  out  4  intervals remaining, including the current one
- ctr_counter_on  out  1  count enable to the counter
- ctr_count_up  out  1  direction to the counter
- ctr_load  out  1  synchronous load to the counter
- ctr_data_in  out  4  load value to the counter
- ctr_count  in  4  counter value
- ctr_TC  in  1  counter terminal count

## Operation
- Counter contract relied on:
  - load has priority over count.
  - When counting, the counter steps up 0→9 and wraps to 0, or steps down 9→0 and wraps to 9.
  - TC is combinational: high when count==9 with count_up=1, or count==0 with count_up=0.
- FSM states are IDLE, LOAD, RUN and DONE.
- IDLE:
  - All counter controls are 0.
  - On start: capture mode_q, reps_q and preset_q. A preset above 9 (10–15) is clamped to 9.
  - If reps==0, go to DONE. Otherwise go to LOAD.
- LOAD:
  - ctr_load=1, ctr_data_in=preset_q, ctr_count_up=mode_q.
  - Next state is always RUN.
- RUN:
  - ctr_count_up=mode_q.
  - ctr_counter_on = ~pause & ~ctr_TC, so the counter parks on its terminal value and never wraps.
  - ctr_TC high → tick=1 and reps_left decrements at the edge. If reps_left was 1, go to DONE; otherwise go to LOAD.
  - ctr_TC is acted on even while pause is high.
- DONE:
  - done=1 for one cycle, then return to IDLE.
- abort:
  - In LOAD, RUN or DONE: go to IDLE on the next edge, with aborted=1 for that one cycle and all counter controls 0.
  - No done pulse and no tick are produced in the abort cycle.
  - abort in IDLE is ignored; start and abort together in IDLE starts the run.
- start while busy is ignored.
- ctr_data_in holds preset_q in all states; it only matters when ctr_load=1.
- reps_left equals reps_q after start, decrements per tick, and is 0 in IDLE after done or abort.

## Timing
- Reset (synchronous):
  - State returns to IDLE.
  - busy, done, aborted, tick, ctr_counter_on, ctr_count_up and ctr_load are 0.
  - ctr_data_in, reps_left and all captured registers are 0.
  - Reset mid-run stops the counter on the next edge; no done or aborted pulse.
- Edge numbering: start is sampled at edge 0. Edge 0 enters LOAD; edge 1 loads the counter.
- Interval length with no pause is k+2 cycles:
  - Down mode: k = preset_q.
  - Up mode: k = 9 − preset_q.
  - The +2 is the LOAD cycle plus the TC cycle.
- Each pause cycle in RUN, excluding the TC cycle, adds exactly one cycle.
- tick is high in the last cycle of each interval. done is high in the cycle after the final tick.
- reps==0: done is high in the cycle after edge 0, and busy never rises.

## Test plan
- Down mode, preset=5, reps=1:
  - ctr_load high after edge 0; ctr_count sequence 5,4,3,2,1,0.
  - tick between edges 6 and 7; done between edges 7 and 8.
  - busy high from edge 0 to edge 7; counter parks at 0.
- Up mode, preset=7, reps=3:
  - Three ticks, 4 cycles apart, between edges 3–4, 7–8 and 11–12.
  - reps_left steps 3→2→1→0; done between edges 12 and 13.
- preset=12, down mode, reps=1:
  - Counter loads 9; done between edges 11 and 12.
  - Same preset with up mode: TC immediately, tick between edges 1 and 2.
- reps=0: done pulse only; ctr_load never asserted; busy stays 0.
- Down mode, preset=5, reps=1, pause high for 3 cycles during RUN:
  - ctr_counter_on low for those 3 cycles with count frozen; done delayed to between edges 10 and 11.
- abort at edge 3 of the preset=5 down run:
  - aborted between edges 3 and 4; no tick or done; counter frozen at 3.
  - Separately, reset at edge 3: all outputs 0 after the edge; a subsequent start runs normally.

Source files
------------

// File: rtl/decade_timer_ctrl.sv
// Sequencing controller for a single decade counter: loads a preset, counts to
// terminal count, repeats for a programmed number of intervals.
module decade_timer_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic       mode_up,
  input  logic [3:0] preset,
  input  logic [3:0] reps,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       tick,
  output logic [3:0] reps_left,
  output logic       ctr_counter_on,
  output logic       ctr_count_up,
  output logic       ctr_load,
  output logic [3:0] ctr_data_in,
  input  logic [3:0] ctr_count,
  input  logic       ctr_TC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       mode_q_r;
  logic [3:0] preset_q_r;
  logic [3:0] reps_left_r;
  logic       ctr_count_unused_s;

  // Presets beyond the last decimal digit park at 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    if (d > 4'd9) begin
      clamp_digit = 4'd9;
    end else begin
      clamp_digit = d;
    end
  endfunction

  // The counter value itself is only observed through TC.
  assign ctr_count_unused_s = ^ctr_count;

  assign reps_left   = reps_left_r;
  assign ctr_data_in = preset_q_r;

  // State register, run parameter capture and interval bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      mode_q_r    <= 1'b0;
      preset_q_r  <= 4'd0;
      reps_left_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && start) begin
        mode_q_r    <= mode_up;
        preset_q_r  <= clamp_digit(preset);
        reps_left_r <= reps;
      end else if ((state_r != IDLE) && abort) begin
        reps_left_r <= 4'd0;
      end else if (tick) begin
        reps_left_r <= reps_left_r - 4'd1;
      end else begin
        reps_left_r <= reps_left_r;
      end
    end
  end

  // Next-state and output decode; abort forces all counter controls low.
  always_comb begin
    state_nxt_s    = state_r;
    busy           = 1'b0;
    done           = 1'b0;
    aborted        = 1'b0;
    tick           = 1'b0;
    ctr_counter_on = 1'b0;
    ctr_count_up   = 1'b0;
    ctr_load       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = (reps == 4'd0) ? DONE : LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (abort) begin
          aborted     = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          ctr_load     = 1'b1;
          ctr_count_up = mode_q_r;
          state_nxt_s  = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          aborted     = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          ctr_count_up   = mode_q_r;
          // Gating on TC parks the counter on its terminal value.
          ctr_counter_on = ~pause & ~ctr_TC;
          if (ctr_TC) begin
            tick        = 1'b1;
            state_nxt_s = (reps_left_r == 4'd1) ? DONE : LOAD;
          end else begin
            state_nxt_s = RUN;
          end
        end
      end
      DONE: begin
        if (abort) begin
          aborted = 1'b1;
        end else begin
          done = 1'b1;
        end
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

endmodule
